// File: rtl/fft_pkg.sv
// Shared constants and FSM encoding for the FFT write-back slice.
package fft_pkg;

   localparam int WORD_W = 74;
   localparam int HALF_W = WORD_W / 2;
   localparam int ADDR_W = 4;
   localparam int PAIR_W = 2 * ADDR_W;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } wb_state_t;

endpackage

// File: rtl/fft_addr_fifo.sv
// Address-tag FIFO: DEPTH x WIDTH, combinational head, extra-MSB pointers for full/empty.
module fft_addr_fifo
   import fft_pkg::*;
#(
   parameter int WIDTH = PAIR_W,
   parameter int DEPTH = 4
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             clr_i,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic [WIDTH-1:0] data_i,
   output logic [WIDTH-1:0] data_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int PW = $clog2(DEPTH) + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wp_q, wp_d;
   logic [PW-1:0]    rp_q, rp_d;

   always_comb begin
      wp_d = wp_q;
      rp_d = rp_q;
      if (clr_i) begin
         wp_d = '0;
         rp_d = '0;
      end else begin
         if (push_i) wp_d = wp_q + PW'(1);
         if (pop_i)  rp_d = rp_q + PW'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wp_q <= '0;
         rp_q <= '0;
      end else begin
         wp_q <= wp_d;
         rp_q <= rp_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push_i && !clr_i) mem_q[wp_q[PW-2:0]] <= data_i;
   end

   assign data_o  = mem_q[rp_q[PW-2:0]];
   assign empty_o = (wp_q == rp_q);
   assign full_o  = (wp_q[PW-1] != rp_q[PW-1]) && (wp_q[PW-2:0] == rp_q[PW-2:0]);

endmodule

// File: rtl/fft_writeback.sv
// FFT layer write-back: tags read-address pairs, writes butterfly results to the opposite bank.
// Optional FFT_WB_SCALE_EN: arithmetic >>1 of every real/imag half before registering.
module fft_writeback
   import fft_pkg::*;
#(
   parameter int FFT_SIZE   = 8,
   parameter int MEM_OFFSET = 8,
   parameter int ADDR_SIZE  = ADDR_W,
   parameter int WORD_SIZE  = WORD_W,
   parameter int TAG_DEPTH  = 4
) (
   input  logic                 i_CLK,
   input  logic                 i_RST,
   input  logic                 i_CS,
   input  logic                 i_rden,
   input  logic [ADDR_SIZE-1:0] i_rdaddr_A,
   input  logic [ADDR_SIZE-1:0] i_rdaddr_B,
   input  logic                 i_layer_done,
   input  logic                 i_bf_valid,
   input  logic [WORD_SIZE-1:0] i_bf_A,
   input  logic [WORD_SIZE-1:0] i_bf_B,
   output logic                 o_wren,
   output logic [ADDR_SIZE-1:0] o_wraddr_A,
   output logic [ADDR_SIZE-1:0] o_wraddr_B,
   output logic [WORD_SIZE-1:0] o_wrdata_A,
   output logic [WORD_SIZE-1:0] o_wrdata_B,
   output logic                 o_busy,
   output logic                 o_done,
   output logic                 o_err
);

   localparam int NBF = FFT_SIZE / 2;
   localparam int CW  = $clog2(NBF) + 1;
   localparam int PW2 = 2 * ADDR_SIZE;
   localparam logic [ADDR_SIZE-1:0] OFS = ADDR_SIZE'(MEM_OFFSET);

`ifdef FFT_WB_SCALE_EN
   localparam int HW = WORD_SIZE / 2;
   function automatic logic [WORD_SIZE-1:0] scale_word(input logic [WORD_SIZE-1:0] w);
      logic [HW-1:0] re, im;
      re = w[WORD_SIZE-1:HW];
      im = w[HW-1:0];
      return {re[HW-1], re[HW-1:1], im[HW-1], im[HW-1:1]};
   endfunction
`else
   function automatic logic [WORD_SIZE-1:0] scale_word(input logic [WORD_SIZE-1:0] w);
      return w;
   endfunction
`endif

   wb_state_t            state_q, state_d;
   logic                 ld_q, ld_d;
   logic [CW-1:0]        count_q, count_d;
   logic                 err_q, err_d;
   logic                 wren_q, wren_d;
   logic [ADDR_SIZE-1:0] wra_q, wra_d, wrb_q, wrb_d;
   logic [WORD_SIZE-1:0] wda_q, wda_d, wdb_q, wdb_d;

   logic                 push_req, pop_req, thru, fifo_push, fifo_pop, do_wr, sat, seen;
   logic                 fifo_full, fifo_empty, fifo_clr;
   logic [PW2-1:0]       push_pair, fifo_head, head;

   assign push_pair = {i_rdaddr_A ^ OFS, i_rdaddr_B ^ OFS};
   assign fifo_clr  = (state_q == IDLE);

   fft_addr_fifo #(
      .WIDTH (PW2),
      .DEPTH (TAG_DEPTH)
   ) u_fifo (
      .clk_i   (i_CLK),
      .rst_ni  (i_RST),
      .clr_i   (fifo_clr),
      .push_i  (fifo_push),
      .pop_i   (fifo_pop),
      .data_i  (push_pair),
      .data_o  (fifo_head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   // An empty-FIFO push+pop bypasses storage so the tag is written through in the same cycle.
   always_comb begin
      push_req  = i_rden && (state_q == RUN);
      pop_req   = i_bf_valid && ((state_q == RUN) || (state_q == DRAIN));
      thru      = push_req && pop_req && fifo_empty;
      fifo_push = push_req && !thru && (!fifo_full || pop_req);
      fifo_pop  = pop_req && !fifo_empty;
      sat       = (count_q == CW'(NBF));
      do_wr     = (fifo_pop || thru) && !sat;
      head      = thru ? push_pair : fifo_head;
      seen      = ld_q || i_layer_done;
   end

   always_comb begin
      state_d = state_q;
      ld_d    = ld_q;
      count_d = count_q;
      err_d   = err_q;
      wren_d  = 1'b0;
      wra_d   = wra_q;
      wrb_d   = wrb_q;
      wda_d   = wda_q;
      wdb_d   = wdb_q;

      if (push_req && fifo_full && !pop_req) err_d = 1'b1;
      if (pop_req && fifo_empty && !push_req) err_d = 1'b1;
      if (pop_req && (fifo_pop || thru) && sat) err_d = 1'b1;
      if (i_rden && (state_q == DRAIN)) err_d = 1'b1;

      if (do_wr) begin
         wren_d  = 1'b1;
         wra_d   = head[PW2-1:ADDR_SIZE];
         wrb_d   = head[ADDR_SIZE-1:0];
         wda_d   = scale_word(i_bf_A);
         wdb_d   = scale_word(i_bf_B);
         count_d = count_q + CW'(1);
      end

      case (state_q)
         IDLE: begin
            ld_d    = 1'b0;
            count_d = '0;
            if (i_CS) state_d = RUN;
         end
         RUN: begin
            if (i_layer_done) ld_d = 1'b1;
            if (seen && !fifo_empty)    state_d = DRAIN;
            else if (seen && sat)       state_d = DONE;
         end
         DRAIN: begin
            if (sat && fifo_empty) state_d = DONE;
         end
         DONE: begin
            if (!i_CS) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_CLK or negedge i_RST) begin
      if (!i_RST) begin
         state_q <= IDLE;
         ld_q    <= 1'b0;
         count_q <= '0;
         err_q   <= 1'b0;
         wren_q  <= 1'b0;
         wra_q   <= '0;
         wrb_q   <= '0;
         wda_q   <= '0;
         wdb_q   <= '0;
      end else begin
         state_q <= state_d;
         ld_q    <= ld_d;
         count_q <= count_d;
         err_q   <= err_d;
         wren_q  <= wren_d;
         wra_q   <= wra_d;
         wrb_q   <= wrb_d;
         wda_q   <= wda_d;
         wdb_q   <= wdb_d;
      end
   end

   assign o_wren     = wren_q;
   assign o_wraddr_A = wra_q;
   assign o_wraddr_B = wrb_q;
   assign o_wrdata_A = wda_q;
   assign o_wrdata_B = wdb_q;
   assign o_busy     = (state_q == RUN) || (state_q == DRAIN);
   assign o_done     = (state_q == DONE);
   assign o_err      = err_q;

endmodule

// File: tb/tb_fft_writeback.sv
// Directed bench for fft_writeback; expectations follow FFT_WB_SCALE_EN when defined.
module tb_fft_writeback;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cs, rden, layer_done, bf_valid;
   logic [3:0]  rda, rdb;
   logic [73:0] bfa, bfb;
   logic        wren, busy, done, err;
   logic [3:0]  wra, wrb;
   logic [73:0] wda, wdb;

   int unsigned total = 0;
   int unsigned bad   = 0;

   always #5 clk = ~clk;

   fft_writeback dut (
      .i_CLK        (clk),
      .i_RST        (rst_n),
      .i_CS         (cs),
      .i_rden       (rden),
      .i_rdaddr_A   (rda),
      .i_rdaddr_B   (rdb),
      .i_layer_done (layer_done),
      .i_bf_valid   (bf_valid),
      .i_bf_A       (bfa),
      .i_bf_B       (bfb),
      .o_wren       (wren),
      .o_wraddr_A   (wra),
      .o_wraddr_B   (wrb),
      .o_wrdata_A   (wda),
      .o_wrdata_B   (wdb),
      .o_busy       (busy),
      .o_done       (done),
      .o_err        (err)
   );

   // Expected word for a small non-negative value carried in the imag half.
   function automatic logic [73:0] exp_word(input int unsigned v);
`ifdef FFT_WB_SCALE_EN
      return 74'(v / 2);
`else
      return 74'(v);
`endif
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic quiet;
      rden = 1'b0; bf_valid = 1'b0; layer_done = 1'b0;
      rda = '0; rdb = '0; bfa = '0; bfb = '0;
   endtask

   task automatic test_reset;
      cs = 1'b0;
      quiet();
      rden = 1'b1; bf_valid = 1'b1; bfa = 74'h3; bfb = 74'h5;
      rst_n = 1'b0;
      tick();
      total++;
      if ({wren, wra, wrb, wda, wdb, busy, done, err} !== '0) begin
         bad++; $display("FAIL reset_outputs: got wren=%b busy=%b done=%b err=%b wda=%h, want all 0", wren, busy, done, err, wda);
      end
      rst_n = 1'b1;
      tick();
      total++;
      if (wren !== 1'b0 || err !== 1'b0) begin
         bad++; $display("FAIL idle_pop_ignored: wren=%b err=%b, want 0 0", wren, err);
      end
      quiet();
   endtask

   task automatic test_nominal;
      cs = 1'b1;
      tick();
      total++;
      if (busy !== 1'b1) begin bad++; $display("FAIL nominal_busy: got %b want 1", busy); end
      for (int c = 0; c < 7; c++) begin
         quiet();
         if (c < 4) begin rden = 1'b1; rda = 4'(8 + c); rdb = 4'(12 + c); end
         if (c >= 3) begin bf_valid = 1'b1; bfa = 74'(c - 3); bfb = 74'(c - 3 + 100); end
         layer_done = (c == 4);
         tick();
         total++;
         if (wren !== (c >= 3)) begin bad++; $display("FAIL nominal_wren c%0d: got %b want %b", c, wren, (c >= 3)); end
         if (c >= 3) begin
            total++;
            if (wra !== 4'(c - 3) || wrb !== 4'(c + 1)) begin
               bad++; $display("FAIL nominal_addr c%0d: got {%0d,%0d} want {%0d,%0d}", c, wra, wrb, c - 3, c + 1);
            end
            total++;
            if (wda !== exp_word(c - 3) || wdb !== exp_word(c + 97)) begin
               bad++; $display("FAIL nominal_data c%0d: got %h %h want %h %h", c, wda, wdb, exp_word(c - 3), exp_word(c + 97));
            end
         end
      end
      quiet();
      tick();
      total++;
      if (done !== 1'b1 || busy !== 1'b0 || err !== 1'b0 || wren !== 1'b0) begin
         bad++; $display("FAIL nominal_done: done=%b busy=%b err=%b wren=%b want 1 0 0 0", done, busy, err, wren);
      end
      total++;
      if (wra !== 4'd3 || wda !== exp_word(3)) begin
         bad++; $display("FAIL hold_last: wra=%0d wda=%h want 3 %h", wra, wda, exp_word(3));
      end
      tick();
      total++;
      if (done !== 1'b1) begin bad++; $display("FAIL done_hold: got %b want 1", done); end
      cs = 1'b0;
      tick();
      total++;
      if (done !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL done_to_idle: done=%b busy=%b want 0 0", done, busy); end
   endtask

   task automatic test_full;
      test_reset();
      cs = 1'b1;
      tick();
      for (int c = 0; c < 10; c++) begin
         quiet();
         if (c < 4) begin rden = 1'b1; rda = 4'(8 + c); rdb = 4'(12 + c); end
         if (c == 4) begin rden = 1'b1; rda = 4'd12; rdb = 4'd8; end
         if (c == 5) begin rden = 1'b1; rda = 4'd13; rdb = 4'd9; end
         if (c == 4 || c >= 6) begin bf_valid = 1'b1; bfa = 74'(c); bfb = 74'(c + 50); end
         tick();
         if (c == 4) begin
            total++;
            if (wren !== 1'b1 || wra !== 4'd0 || wrb !== 4'd4 || err !== 1'b0) begin
               bad++; $display("FAIL full_simul: wren=%b addr={%0d,%0d} err=%b want 1 {0,4} 0", wren, wra, wrb, err);
            end
         end
         if (c == 5) begin
            total++;
            if (wren !== 1'b0 || err !== 1'b1) begin
               bad++; $display("FAIL overflow: wren=%b err=%b want 0 1", wren, err);
            end
         end
         if (c >= 6 && c <= 8) begin
            total++;
            if (wren !== 1'b1 || wra !== 4'(c - 5) || wrb !== 4'(c - 1) || wda !== exp_word(c)) begin
               bad++; $display("FAIL full_drain c%0d: wren=%b addr={%0d,%0d} wda=%h want 1 {%0d,%0d} %h", c, wren, wra, wrb, wda, c - 5, c - 1, exp_word(c));
            end
         end
         if (c == 9) begin
            total++;
            if (wren !== 1'b0 || wra !== 4'd3) begin
               bad++; $display("FAIL saturate: wren=%b wra=%0d want 0 3", wren, wra);
            end
         end
      end
      quiet();
      layer_done = 1'b1;
      tick();
      quiet();
      total++;
      if (done !== 1'b1 || err !== 1'b1) begin
         bad++; $display("FAIL run_to_done: done=%b err=%b want 1 1", done, err);
      end
      cs = 1'b0;
      tick();
   endtask

   task automatic test_underflow;
      test_reset();
      cs = 1'b1;
      tick();
      bf_valid = 1'b1; bfa = 74'h9;
      tick();
      quiet();
      total++;
      if (wren !== 1'b0 || err !== 1'b1) begin
         bad++; $display("FAIL underflow: wren=%b err=%b want 0 1", wren, err);
      end
      tick(); tick();
      total++;
      if (err !== 1'b1 || busy !== 1'b1) begin bad++; $display("FAIL err_sticky: err=%b busy=%b want 1 1", err, busy); end
   endtask

   task automatic test_drain_rden;
      test_reset();
      cs = 1'b1;
      tick();
      rden = 1'b1; rda = 4'd8; rdb = 4'd12;
      tick();
      quiet();
      layer_done = 1'b1;
      tick();
      quiet();
      rden = 1'b1; rda = 4'd9; rdb = 4'd13;
      tick();
      quiet();
      total++;
      if (err !== 1'b1 || busy !== 1'b1 || wren !== 1'b0) begin
         bad++; $display("FAIL drain_rden: err=%b busy=%b wren=%b want 1 1 0", err, busy, wren);
      end
   endtask

   task automatic test_midpass_reset;
      test_reset();
      cs = 1'b1;
      tick();
      for (int c = 0; c < 4; c++) begin
         quiet();
         if (c < 2) begin rden = 1'b1; rda = 4'(8 + c); rdb = 4'(12 + c); end
         else begin bf_valid = 1'b1; bfa = 74'(c + 20); bfb = 74'(c + 40); end
         tick();
      end
      quiet();
      total++;
      if (wren !== 1'b1 || wra !== 4'd1) begin bad++; $display("FAIL mid_second_write: wren=%b wra=%0d want 1 1", wren, wra); end
      #2 rst_n = 1'b0;
      #1;
      total++;
      if ({wren, wra, wrb, wda, wdb, busy, done, err} !== '0) begin
         bad++; $display("FAIL mid_reset_async: wren=%b wra=%0d wda=%h busy=%b want all 0", wren, wra, wda, busy);
      end
      cs = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      test_nominal();
   endtask

   task automatic test_write_through;
      test_reset();
      cs = 1'b1;
      tick();
      rden = 1'b1; rda = 4'd8; rdb = 4'd12;
      bf_valid = 1'b1; bfa = 74'd7; bfb = 74'd107;
      tick();
      quiet();
      total++;
      if (wren !== 1'b1 || wra !== 4'd0 || wrb !== 4'd4 || wda !== exp_word(7) || wdb !== exp_word(107) || err !== 1'b0) begin
         bad++; $display("FAIL write_through: wren=%b addr={%0d,%0d} data=%h %h err=%b", wren, wra, wrb, wda, wdb, err);
      end
      tick();
      total++;
      if (wren !== 1'b0) begin bad++; $display("FAIL wren_one_cycle: got %b want 0", wren); end
   endtask

   task automatic test_scale;
      logic [36:0] re, im, ere, eim;
      test_reset();
      cs = 1'b1;
      tick();
      re = 37'h10;
      im = -37'sd3;
`ifdef FFT_WB_SCALE_EN
      ere = 37'h8;
      eim = -37'sd2;
`else
      ere = re;
      eim = im;
`endif
      rden = 1'b1; rda = 4'd10; rdb = 4'd14;
      bf_valid = 1'b1; bfa = {re, im}; bfb = {im, re};
      tick();
      quiet();
      total++;
      if (wren !== 1'b1 || wda !== {ere, eim} || wdb !== {eim, ere}) begin
         bad++; $display("FAIL scale: wda=%h wdb=%h want %h %h", wda, wdb, {ere, eim}, {eim, ere});
      end
   endtask

   initial begin
      rst_n = 1'b0;
      cs = 1'b0;
      quiet();
      test_reset();
      test_nominal();
      test_full();
      test_underflow();
      test_drain_rden();
      test_midpass_reset();
      test_write_through();
      test_scale();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
